instr_cache_assoc: RTL and testbench

Parametrised set-associative successor to the direct-mapped instruction cache. Sits between the fetch stage and the memory/bus interface. Adds:
- a valid/ready request handshake with the fetch stage;
- an internal miss/refill state machine;
- per-set round-robin replacement;
- misaligned-fetch detection;
- whole-cache invalidation (fence.i).

WAY_COUNT = 1 degenerates to a direct-mapped cache with the same interface.

---
 rtl/icache_pkg.sv | 38 +++
 rtl/icache_way.sv | 59 +++++
 rtl/instr_cache_assoc.sv | 220 ++++++++++++++++++++++
 tb/tb_instr_cache_assoc.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-geometry helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum int {
    GEOM_BYTE_OFF = 0,
    GEOM_WORD_OFF = 1,
    GEOM_INDEX    = 2,
    GEOM_TAG      = 3
  } geom_e;

  // Width of one address field; the tag takes whatever the offsets and index leave over.
  function automatic int geom_width(geom_e kind, int addr_w, int word_size,
                                    int word_count, int set_count);
    int b_w;
    int w_w;
    int i_w;
    b_w = $clog2(word_size / 8);
    w_w = $clog2(word_count);
    i_w = $clog2(set_count);
    case (kind)
      GEOM_BYTE_OFF: return b_w;
      GEOM_WORD_OFF: return w_w;
      GEOM_INDEX:    return i_w;
      default:       return addr_w - b_w - w_w - i_w;
    endcase
  endfunction

  function automatic int at_least_one(int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag, valid and data arrays with a single write port and an
// asynchronous lookup port that compares the stored tag against the request.
module icache_way
  import icache_pkg::*;
#(
  parameter int IDX_W   = 7,
  parameter int TAG_W   = 51,
  parameter int BLOCK_W = 512,
  parameter int SETS    = 128
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               i_flush,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_block,
  input  logic [IDX_W-1:0]   i_rd_idx,
  input  logic [TAG_W-1:0]   i_rd_tag,
  output logic               o_valid,
  output logic               o_hit,
  output logic [BLOCK_W-1:0] o_rd_block
);

  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [BLOCK_W-1:0] data_mem [SETS];
  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    valid_d;

  // Flush wins over a same-cycle write; the FSM never issues both together.
  always_comb begin
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = '0;
    end else if (i_we) begin
      valid_d[i_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      tag_mem[i_wr_idx]  <= i_wr_tag;
      data_mem[i_wr_idx] <= i_wr_block;
    end
  end

  assign o_valid    = valid_q[i_rd_idx];
  assign o_hit      = o_valid && (tag_mem[i_rd_idx] == i_rd_tag);
  assign o_rd_block = data_mem[i_rd_idx];

endmodule

// File: rtl/instr_cache_assoc.sv
// Set-associative instruction cache: request handshake, miss/refill FSM,
// per-set round-robin replacement, misalignment detection and full invalidation.
module instr_cache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_SIZE  = 32,
  parameter int WORD_COUNT = 16,
  parameter int SET_COUNT  = 128,
  parameter int WAY_COUNT  = 2
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic                             i_req_valid,
  input  logic [ADDR_WIDTH-1:0]            i_req_addr,
  output logic                             o_req_ready,
  output logic                             o_rsp_valid,
  output logic [WORD_SIZE-1:0]             o_rsp_instr,
  output logic                             o_rsp_misaligned,
  input  logic                             i_flush,
  output logic                             o_mem_req,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  input  logic                             i_mem_valid,
  input  logic [WORD_COUNT*WORD_SIZE-1:0]  i_mem_block
);

  localparam int BLOCK_WIDTH = WORD_COUNT * WORD_SIZE;
  localparam int BOFF_W   = geom_width(GEOM_BYTE_OFF, ADDR_WIDTH, WORD_SIZE, WORD_COUNT, SET_COUNT);
  localparam int WOFF_W   = geom_width(GEOM_WORD_OFF, ADDR_WIDTH, WORD_SIZE, WORD_COUNT, SET_COUNT);
  localparam int IDX_BITS = geom_width(GEOM_INDEX,    ADDR_WIDTH, WORD_SIZE, WORD_COUNT, SET_COUNT);
  localparam int TAG_W    = geom_width(GEOM_TAG,      ADDR_WIDTH, WORD_SIZE, WORD_COUNT, SET_COUNT);
  localparam int OFF_W    = BOFF_W + WOFF_W;
  localparam int IDX_W    = at_least_one(IDX_BITS);
  localparam int WSEL_W   = at_least_one(WOFF_W);
  localparam int WAY_W    = at_least_one($clog2(WAY_COUNT));

  localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = (ADDR_WIDTH'(1) << BOFF_W) - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = (ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK  = ADDR_WIDTH'(SET_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] WSEL_MASK = ADDR_WIDTH'(WORD_COUNT - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0]    rsp_instr_q, rsp_instr_d;
  logic                    rsp_mis_q, rsp_mis_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WAY_W-1:0]        ptr_q [SET_COUNT];

  logic [ADDR_WIDTH-1:0]   lk_addr;
  logic [IDX_W-1:0]        lk_idx;
  logic [TAG_W-1:0]        lk_tag;
  logic [WSEL_W-1:0]       req_word;
  logic [WSEL_W-1:0]       refill_word;
  logic                    req_accept;
  logic                    req_misaligned;
  logic                    refill_fire;
  logic                    way_flush;

  logic [WAY_COUNT-1:0]    way_valid;
  logic [WAY_COUNT-1:0]    way_hit;
  logic [WAY_COUNT-1:0]    way_we;
  logic [BLOCK_WIDTH-1:0]  way_block [WAY_COUNT];

  logic                    hit_any;
  logic [WAY_W-1:0]        hit_way;
  logic [BLOCK_WIDTH-1:0]  hit_block;
  logic [WORD_SIZE-1:0]    hit_word;
  logic [WORD_SIZE-1:0]    refill_data;
  logic                    inv_any;
  logic [WAY_W-1:0]        inv_way;
  logic [WAY_W-1:0]        victim;
  logic [WAY_W-1:0]        ptr_cur;
  logic [WAY_W-1:0]        ptr_d;
  logic                    ptr_we;

  assign o_req_ready      = (state_q == IDLE) && !i_flush;
  assign o_rsp_valid      = rsp_valid_q;
  assign o_rsp_instr      = rsp_instr_q;
  assign o_rsp_misaligned = rsp_mis_q;
  assign o_mem_req        = mem_req_q;
  assign o_mem_addr       = mem_addr_q;

  assign req_accept     = i_req_valid && o_req_ready;
  assign req_misaligned = |(i_req_addr & BYTE_MASK);
  assign refill_fire    = (state_q == REFILL) && i_mem_valid;
  assign way_flush      = (state_q == IDLE) && i_flush;

  // Lookups use the live request while idle and the held miss address during refill.
  assign lk_addr     = (state_q == IDLE) ? i_req_addr : addr_q;
  assign lk_idx      = IDX_W'((lk_addr >> OFF_W) & IDX_MASK);
  assign lk_tag      = TAG_W'(lk_addr >> (OFF_W + IDX_BITS));
  assign req_word    = WSEL_W'((i_req_addr >> BOFF_W) & WSEL_MASK);
  assign refill_word = WSEL_W'((addr_q >> BOFF_W) & WSEL_MASK);

  generate
    for (genvar gi = 0; gi < WAY_COUNT; gi++) begin : g_way
      assign way_we[gi] = refill_fire && (victim == WAY_W'(gi));

      icache_way #(
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .BLOCK_W (BLOCK_WIDTH),
        .SETS    (SET_COUNT)
      ) u_way (
        .clk        (clk),
        .arstn      (arstn),
        .i_flush    (way_flush),
        .i_we       (way_we[gi]),
        .i_wr_idx   (lk_idx),
        .i_wr_tag   (lk_tag),
        .i_wr_block (i_mem_block),
        .i_rd_idx   (lk_idx),
        .i_rd_tag   (lk_tag),
        .o_valid    (way_valid[gi]),
        .o_hit      (way_hit[gi]),
        .o_rd_block (way_block[gi])
      );
    end
  endgenerate

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign hit_block   = way_block[hit_way];
  assign hit_word    = hit_block[req_word * WORD_SIZE +: WORD_SIZE];
  assign refill_data = i_mem_block[refill_word * WORD_SIZE +: WORD_SIZE];

  assign ptr_cur = ptr_q[lk_idx];
  assign victim  = inv_any ? inv_way : ptr_cur;
  assign ptr_we  = refill_fire && !inv_any;
  assign ptr_d   = (WAY_COUNT == 1) ? '0 : ptr_cur + WAY_W'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_instr_d = rsp_instr_q;
    rsp_mis_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (req_accept) begin
          addr_d = i_req_addr;
          if (req_misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
            rsp_instr_d = '0;
          end else if (hit_any) begin
            rsp_valid_d = 1'b1;
            rsp_instr_d = hit_word;
          end else begin
            state_d    = REFILL;
            mem_req_d  = 1'b1;
            mem_addr_d = i_req_addr & ~OFF_MASK;
          end
        end
      end
      REFILL: begin
        if (i_mem_valid) begin
          state_d     = RESPOND;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_instr_d = refill_data;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_mis_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        ptr_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_mis_q   <= rsp_mis_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      if (ptr_we) begin
        ptr_q[lk_idx] <= ptr_d;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache_assoc.sv
// Self-checking bench: directed scenarios followed by random fetches, all
// compared against an abstract cache model that tracks per-set contents.
module tb_instr_cache_assoc;

  localparam int AW    = 64;
  localparam int WS    = 32;
  localparam int WC    = 16;
  localparam int SETS  = 128;
  localparam int WAYS  = 2;
  localparam int BW    = WC * WS;
  localparam int BLK_B = WC * WS / 8;

  logic          clk = 1'b0;
  logic          arstn = 1'b1;
  logic          i_req_valid = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic          o_req_ready;
  logic          o_rsp_valid;
  logic [WS-1:0] o_rsp_instr;
  logic          o_rsp_misaligned;
  logic          i_flush = 1'b0;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_valid = 1'b0;
  logic [BW-1:0] i_mem_block = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what each set holds, abstractly.
  bit        mdl_valid [SETS][WAYS];
  longint    mdl_tag   [SETS][WAYS];
  int        mdl_ptr   [SETS];

  instr_cache_assoc #(
    .ADDR_WIDTH (AW),
    .WORD_SIZE  (WS),
    .WORD_COUNT (WC),
    .SET_COUNT  (SETS),
    .WAY_COUNT  (WAYS)
  ) dut (
    .clk              (clk),
    .arstn            (arstn),
    .i_req_valid      (i_req_valid),
    .i_req_addr       (i_req_addr),
    .o_req_ready      (o_req_ready),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_instr      (o_rsp_instr),
    .o_rsp_misaligned (o_rsp_misaligned),
    .i_flush          (i_flush),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_valid      (i_mem_valid),
    .i_mem_block      (i_mem_block)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: block at base 0x1000 holds 0xA0+k; other blocks differ per base.
  function automatic logic [31:0] mem_word(input logic [63:0] base, input int k);
    logic [63:0] d;
    d = ((base - 64'h1000) >> 6) * 64'h0100_0193;
    return d[31:0] + 32'hA0 + 32'(k);
  endfunction

  function automatic logic [BW-1:0] mem_block(input logic [63:0] base);
    logic [BW-1:0] b;
    for (int k = 0; k < WC; k++) b[k*WS +: WS] = mem_word(base, k);
    return b;
  endfunction

  function automatic int set_of(input logic [63:0] a);
    return int'((a / BLK_B) % SETS);
  endfunction

  function automatic longint tag_of(input logic [63:0] a);
    return longint'(a / (BLK_B * SETS));
  endfunction

  function automatic int mdl_find(input logic [63:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (mdl_valid[s][w] && mdl_tag[s][w] == tag_of(a)) return w;
    return -1;
  endfunction

  task automatic mdl_fill(input logic [63:0] a);
    int s;
    int v;
    s = set_of(a);
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!mdl_valid[s][w]) v = w;
    if (v < 0) begin
      v = mdl_ptr[s];
      mdl_ptr[s] = (mdl_ptr[s] + 1) % WAYS;
    end
    mdl_valid[s][v] = 1'b1;
    mdl_tag[s][v]   = tag_of(a);
  endtask

  task automatic mdl_reset(input bit also_ptr);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mdl_valid[s][w] = 1'b0;
      if (also_ptr) mdl_ptr[s] = 0;
    end
  endtask

  // One full fetch; optionally raises i_flush while the refill is outstanding.
  task automatic fetch(input logic [63:0] a, input int lat, input bit flush_in_refill);
    logic [63:0] base;
    logic [31:0] exp_word;
    string       kind;
    base     = a & ~64'(BLK_B - 1);
    exp_word = mem_word(base, int'((a / 4) % WC));
    @(negedge clk);
    chk("ready_idle", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    @(negedge clk);
    i_req_valid = 1'b0;
    if (a[1:0] != 2'b00) begin
      kind = "misaligned";
      chk("mis_valid", o_rsp_valid, 1);
      chk("mis_flag", o_rsp_misaligned, 1);
      chk("mis_instr", o_rsp_instr, 0);
      chk("mis_memreq", o_mem_req, 0);
    end else if (mdl_find(a) >= 0) begin
      kind = "hit";
      chk("hit_valid", o_rsp_valid, 1);
      chk("hit_flag", o_rsp_misaligned, 0);
      chk("hit_instr", o_rsp_instr, exp_word);
      chk("hit_memreq", o_mem_req, 0);
    end else begin
      kind = "miss";
      chk("miss_novalid", o_rsp_valid, 0);
      chk("miss_memreq", o_mem_req, 1);
      chk("miss_memaddr", o_mem_addr, base);
      chk("miss_ready", o_req_ready, 0);
      if (flush_in_refill) i_flush = 1'b1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("refill_hold", o_mem_req, 1);
        chk("refill_norsp", o_rsp_valid, 0);
      end
      i_mem_valid = 1'b1;
      i_mem_block = mem_block(base);
      @(negedge clk);
      i_mem_valid = 1'b0;
      i_mem_block = '0;
      chk("refill_valid", o_rsp_valid, 1);
      chk("refill_instr", o_rsp_instr, exp_word);
      chk("refill_flag", o_rsp_misaligned, 0);
      chk("refill_memreq", o_mem_req, 0);
      chk("respond_ready", o_req_ready, 0);
      mdl_fill(a);
      @(negedge clk);
      chk("post_rsp_idle", o_rsp_valid, 0);
      if (flush_in_refill) begin
        chk("flush_ready", o_req_ready, 0);
        @(negedge clk);
        i_flush = 1'b0;
        mdl_reset(1'b0);
      end
    end
    $display("fetch addr=%h kind=%s lat=%0d instr=%h", a, kind, lat, o_rsp_instr);
  endtask

  task automatic hit_pair(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    @(negedge clk);
    chk("b2b_ready", o_req_ready, 1);
    i_req_addr = b;
    chk("b2b_first_valid", o_rsp_valid, 1);
    chk("b2b_first_instr", o_rsp_instr, mem_word(a & ~64'(BLK_B - 1), int'((a / 4) % WC)));
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("b2b_second_valid", o_rsp_valid, 1);
    chk("b2b_second_instr", o_rsp_instr, mem_word(b & ~64'(BLK_B - 1), int'((b / 4) % WC)));
    chk("b2b_memreq", o_mem_req, 0);
    $display("pair addr=%h,%h kind=hit,hit instr=%h", a, b, o_rsp_instr);
  endtask

  task automatic do_flush();
    @(negedge clk);
    i_flush = 1'b1;
    #1;
    chk("flush_blocks_ready", o_req_ready, 0);
    @(negedge clk);
    i_flush = 1'b0;
    mdl_reset(1'b0);
    #1;
    chk("flush_release_ready", o_req_ready, 1);
    $display("flush");
  endtask

  task automatic reset_in_refill(input logic [63:0] a);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("rst_pre_memreq", o_mem_req, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    arstn = 1'b0;
    #1;
    chk("rst_memreq_drop", o_mem_req, 0);
    chk("rst_ready", o_req_ready, 1);
    @(negedge clk);
    arstn = 1'b1;
    mdl_reset(1'b1);
    $display("reset during refill addr=%h", a);
  endtask

  initial begin
    logic [63:0] a;
    int          r;
    mdl_reset(1'b1);
    #2;
    arstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_instr", o_rsp_instr, 0);
    chk("rst_rsp_mis", o_rsp_misaligned, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_ready", o_req_ready, 1);
    arstn = 1'b1;

    fetch(64'h1000, 3, 1'b0);
    chk("first_word_a0", o_rsp_instr, 32'hA0);
    hit_pair(64'h1004, 64'h103C);

    fetch(64'h5000, 1, 1'b0);
    fetch(64'h9000, 0, 1'b0);
    chk("evict_1000", mdl_find(64'h1000) < 0, 1);
    fetch(64'h5000, 0, 1'b0);
    fetch(64'h1000, 2, 1'b0);

    fetch(64'h1002, 0, 1'b0);
    fetch(64'hD000, 2, 1'b1);
    fetch(64'h1000, 1, 1'b0);

    reset_in_refill(64'h5000);
    fetch(64'h1000, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do_flush();
      end else begin
        a = (64'($urandom_range(0, 3)) * 64'(BLK_B * SETS))
          + (64'($urandom_range(0, 2) == 0 ? 0 : 64 + $urandom_range(0, 1)) * 64'(BLK_B))
          + 64'($urandom_range(0, WC - 1)) * 64'd4;
        if (r == 1) a = a + 64'($urandom_range(1, 3));
        fetch(a, int'($urandom_range(0, 4)), r == 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
